// File: rtl/fphub_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fphub_mult_arbiter
//  Purpose  : Round-robin sharing of one external HUB multiplier between
//             NUM_REQ requesters, with a tagged, registered output stage.
//  Revision : 1.0
// ============================================================================
module fphub_mult_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int E       = 5,
    parameter int M       = 10,
    parameter int WIDTH   = E + M + 1,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_x_i,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_y_i,
    input  logic                            flush_i,
    output logic [WIDTH-1:0]                mul_x_o,
    output logic [WIDTH-1:0]                mul_y_o,
    input  logic [WIDTH-1:0]                mul_z_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [WIDTH-1:0]                out_result_o,
    output logic [IDW-1:0]                  out_id_o,
    output logic                            busy_o
);

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_result_q, out_result_d;
    logic [IDW-1:0]       out_id_q, out_id_d;
    logic [IDW-1:0]       ptr_q, ptr_d;

    logic                 gnt_found;
    logic [IDW-1:0]       gnt_idx;
    logic [NUM_REQ-1:0]   gnt_oh;
    logic [WIDTH-1:0]     gnt_x;
    logic [WIDTH-1:0]     gnt_y;
    logic                 can_accept;
    logic                 accept;

    // Two descending scans: the wrapped segment (i < ptr) first, then the
    // segment at/after ptr overrides it, so the lowest index >= ptr wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_oh    = '0;
        gnt_x     = '0;
        gnt_y     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i] && (i < int'(ptr_q))) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(i);
                gnt_oh    = '0;
                gnt_oh[i] = 1'b1;
                gnt_x     = req_x_i[i];
                gnt_y     = req_y_i[i];
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i] && (i >= int'(ptr_q))) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(i);
                gnt_oh    = '0;
                gnt_oh[i] = 1'b1;
                gnt_x     = req_x_i[i];
                gnt_y     = req_y_i[i];
            end
        end
    end

    assign can_accept  = !flush_i && (!out_valid_q || out_ready_i);
    assign accept      = gnt_found && can_accept;
    assign req_ready_o = accept ? gnt_oh : '0;
    assign mul_x_o     = gnt_x;
    assign mul_y_o     = gnt_y;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_id_d     = out_id_q;
        ptr_d        = ptr_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_result_d = mul_z_i;
            out_id_d     = gnt_idx;
            ptr_d        = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end else if (flush_i || out_ready_i) begin
            // Drain or flush: payload is left in place, only valid drops.
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_id_q     <= '0;
            ptr_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_id_q     <= out_id_d;
            ptr_q        <= ptr_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_result_o = out_result_q;
    assign out_id_o     = out_id_q;
    assign busy_o       = out_valid_q || (|req_valid_i);

endmodule
`default_nettype wire
